// File: rtl/burst_arbiter.sv
// Round-robin arbiter sharing one 8-beat counter among N_REQ requesters.
// Optional abort support is enabled with the BURST_ARB_ABORT_EN macro.
module burst_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDW   = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             stall,
  input  logic             cnt_co,
`ifdef BURST_ARB_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic             cnt_clean,
  output logic             cnt_en,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             beat,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, next_state;
  logic [IDW-1:0]   gidx, next_gidx;
  logic [IDW-1:0]   last, next_last;
  logic             found;
  logic [IDW-1:0]   win;
  logic [N_REQ-1:0] gnt_oh;
  logic             abort_req;

`ifdef BURST_ARB_ABORT_EN
  logic abrt_q, next_abrt;
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign gnt_oh = N_REQ'(1) << gidx;

  // First requesting index after the previous winner, wrapping modulo N_REQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    next_state = state;
    next_gidx  = gidx;
    next_last  = last;
    cnt_clean  = 1'b0;
    cnt_en     = 1'b0;
    gnt        = '0;
    gnt_id     = '0;
    beat       = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
`ifdef BURST_ARB_ABORT_EN
    next_abrt  = 1'b0;
    aborted    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          next_gidx  = win;
          next_state = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clean  = 1'b1;
        gnt        = gnt_oh;
        gnt_id     = gidx;
        busy       = 1'b1;
        next_state = abort_req ? DONE : RUN;
`ifdef BURST_ARB_ABORT_EN
        next_abrt  = abort_req;
`endif
      end
      RUN: begin
        gnt    = gnt_oh;
        gnt_id = gidx;
        busy   = 1'b1;
        // Abort outranks both stall and the counter's carry-out.
        if (abort_req) begin
          next_state = DONE;
`ifdef BURST_ARB_ABORT_EN
          next_abrt  = 1'b1;
`endif
        end else if (!stall) begin
          cnt_en = 1'b1;
          beat   = 1'b1;
          if (cnt_co) next_state = DONE;
        end
      end
      DONE: begin
        gnt        = gnt_oh;
        gnt_id     = gidx;
        busy       = 1'b1;
        done       = 1'b1;
`ifdef BURST_ARB_ABORT_EN
        aborted    = abrt_q;
`endif
        next_last  = gidx;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gidx  <= '0;
      last  <= IDW'(N_REQ - 1);
    end else begin
      state <= next_state;
      gidx  <= next_gidx;
      last  <= next_last;
    end
  end

`ifdef BURST_ARB_ABORT_EN
  always_ff @(posedge clk) begin
    if (rst) abrt_q <= 1'b0;
    else     abrt_q <= next_abrt;
  end
`endif

endmodule

// File: tb/tb_burst_arbiter.sv
// Directed, table-driven bench for burst_arbiter (N_REQ=2 main table,
// N_REQ=4 round-robin sequence, abort sequence when BURST_ARB_ABORT_EN is set).
module tb_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic       stall;
  logic       cnt_co;
  logic       cnt_clean, cnt_en, beat, done, busy;
  logic [1:0] gnt;
  logic       gnt_id;

  logic       rst4;
  logic [3:0] req4;
  logic       co4;
  logic       clean4, en4, beat4, done4, busy4;
  logic [3:0] gnt4;
  logic [1:0] gid4;

`ifdef BURST_ARB_ABORT_EN
  logic abort, aborted, abort4, aborted4;
`endif

  logic [2:0] cnt  = '0;
  logic [2:0] cnt4 = '0;

  int nApplied    = 0;
  int nMiscompares = 0;

  always #5 clk = ~clk;

  burst_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .rst(rst), .req(req), .stall(stall), .cnt_co(cnt_co),
`ifdef BURST_ARB_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .cnt_clean(cnt_clean), .cnt_en(cnt_en), .gnt(gnt), .gnt_id(gnt_id),
    .beat(beat), .done(done), .busy(busy)
  );

  burst_arbiter #(.N_REQ(4)) dut4 (
    .clk(clk), .rst(rst4), .req(req4), .stall(1'b0), .cnt_co(co4),
`ifdef BURST_ARB_ABORT_EN
    .abort(abort4), .aborted(aborted4),
`endif
    .cnt_clean(clean4), .cnt_en(en4), .gnt(gnt4), .gnt_id(gid4),
    .beat(beat4), .done(done4), .busy(busy4)
  );

  // Environment model of the shared 3-bit beat counter for each instance.
  always @(posedge clk) begin
    if (rst || cnt_clean) cnt <= '0;
    else if (cnt_en)      cnt <= cnt + 3'd1;
    if (rst4 || clean4)   cnt4 <= '0;
    else if (en4)         cnt4 <= cnt4 + 3'd1;
  end
  assign cnt_co = (cnt == 3'd7);
  assign co4    = (cnt4 == 3'd7);

  typedef struct {
    logic       rst;
    logic [1:0] req;
    logic       stall;
    logic [1:0] gnt;
    logic       gid;
    logic       clean;
    logic       beat;
    logic       done;
    logic       busy;
  } vec_t;

  vec_t vecs[$];

  task automatic pushRow(input logic r, input logic [1:0] rq, input logic st,
                         input logic [1:0] g, input logic id, input logic cl,
                         input logic bt, input logic dn, input logic bs);
    vec_t v;
    v.rst = r; v.req = rq; v.stall = st; v.gnt = g; v.gid = id;
    v.clean = cl; v.beat = bt; v.done = dn; v.busy = bs;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] reqAt(input logic [1:0] reqv, input int dropAt, input int c);
    return (dropAt >= 0 && c >= dropAt) ? 2'b00 : reqv;
  endfunction

  // One burst as seen from its sampling IDLE cycle (cycle 0) through DONE.
  task automatic addBurst(input logic [1:0] reqv, input int id,
                          input int stallA, input int stallB, input int dropAt);
    logic [1:0] g;
    int c, beats;
    logic st;
    g = 2'b01 << id;
    pushRow(0, reqAt(reqv, dropAt, 0), 0, 2'b00, 0, 0, 0, 0, 0);
    pushRow(0, reqAt(reqv, dropAt, 1), 0, g, id[0], 1, 0, 0, 1);
    c = 2;
    beats = 0;
    while (beats < 8) begin
      st = (c == stallA) || (c == stallB);
      pushRow(0, reqAt(reqv, dropAt, c), st, g, id[0], 0, !st, 0, 1);
      if (!st) beats++;
      c++;
    end
    pushRow(0, reqAt(reqv, dropAt, c), 1, g, id[0], 0, 0, 1, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst   = v.rst;
    req   = v.req;
    stall = v.stall;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s idx=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic runBurst4(input logic [3:0] reqv, input int expId);
    int beats;
    logic sawDone;
    logic [1:0] idSeen;
    logic [3:0] gntSeen;
    beats = 0; sawDone = 1'b0; idSeen = '0; gntSeen = '0;
    @(negedge clk);
    req4 = reqv;
    for (int c = 0; c < 20 && !sawDone; c++) begin
      #1;
      if (clean4) begin
        idSeen  = gid4;
        gntSeen = gnt4;
      end
      if (beat4) beats++;
      if (done4) begin
        sawDone = 1'b1;
        checkOutput("gnt4_at_done", expId, 32'(gnt4), 32'(4'b0001 << expId));
      end
      if (!sawDone) @(negedge clk);
    end
    checkOutput("burst4_done", expId, 32'(sawDone), 32'd1);
    checkOutput("gnt4_id", expId, 32'(idSeen), 32'(expId));
    checkOutput("gnt4_onehot", expId, 32'(gntSeen), 32'(4'b0001 << expId));
    checkOutput("beats4", expId, 32'(beats), 32'd8);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; req = '0; stall = 1'b0;
    rst4 = 1'b1; req4 = '0;
`ifdef BURST_ARB_ABORT_EN
    abort = 1'b0; abort4 = 1'b0;
`endif

    // After reset last=1 (N=2): req=11 alternates 0,1,0; lone requester may repeat.
    addBurst(2'b11, 0, -1, -1, -1);
    addBurst(2'b11, 1, -1, -1, -1);
    addBurst(2'b11, 0,  4,  5, -1);
    addBurst(2'b01, 0, -1, -1, -1);
    addBurst(2'b10, 1, -1, -1,  3);
    pushRow(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);
    addBurst(2'b11, 0, -1, -1, -1);
    // Reset sampled in cycle 6 of a requester-1 burst; priority returns to 0.
    pushRow(0, 2'b11, 0, 2'b00, 0, 0, 0, 0, 0);
    pushRow(0, 2'b11, 0, 2'b10, 1, 1, 0, 0, 1);
    for (int c = 2; c <= 5; c++) pushRow(0, 2'b11, 0, 2'b10, 1, 0, 1, 0, 1);
    pushRow(1, 2'b11, 0, 2'b10, 1, 0, 1, 0, 1);
    addBurst(2'b11, 0, -1, -1, -1);
    pushRow(0, 2'b00, 0, 2'b00, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_n2", 0, {24'd0, gnt, gnt_id, cnt_clean, cnt_en, beat, done, busy}, 32'd0);
    checkOutput("reset_n4", 0, {22'd0, gnt4, gid4, clean4, en4, beat4, done4, busy4}, 32'd0);
    rst4 = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("row", i,
                  {24'd0, gnt, gnt_id, cnt_clean, cnt_en, beat, done, busy},
                  {24'd0, vecs[i].gnt, vecs[i].gid, vecs[i].clean,
                   vecs[i].beat, vecs[i].beat, vecs[i].done, vecs[i].busy});
    end

    // N_REQ=4: requester 3 alone, then 1010 gives 1 then 3.
    runBurst4(4'b1000, 3);
    runBurst4(4'b1010, 1);
    runBurst4(4'b1010, 3);
    req4 = '0;

`ifdef BURST_ARB_ABORT_EN
    // last=0 here, so req=11 grants requester 1; abort in cycle 5.
    begin
      int beats;
      beats = 0;
      @(negedge clk);
      req = 2'b11;
      for (int c = 0; c <= 8; c++) begin
        if (c > 0) @(negedge clk);
        abort = (c == 5);
        #1;
        if (c <= 5 && beat) beats++;
        if (c == 5) checkOutput("abort_no_beat", c, {30'd0, beat, cnt_en}, 32'd0);
        if (c == 6) begin
          checkOutput("abort_beats", c, 32'(beats), 32'd3);
          checkOutput("abort_done", c, {29'd0, done, aborted, busy}, 32'b111);
          checkOutput("abort_gnt", c, 32'(gnt), 32'b10);
        end
        if (c == 7) checkOutput("abort_idle", c, {30'd0, busy, aborted}, 32'd0);
        if (c == 8) checkOutput("abort_next_clean", c, {29'd0, cnt_clean, gnt}, 32'b101);
      end
      abort = 1'b0;
      req = 2'b00;
      repeat (12) @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
    $finish;
  end

endmodule
